// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter
//  Description : Serves I-cache and D-cache line misses one at a time on a
//                single physical-memory port. Ties go round-robin. Address
//                and write data are latched at grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // I-cache side
   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_address,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   // D-cache side
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_address,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   // Physical-memory side
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  grant_dcache_q, grant_dcache_d;
   logic                  last_grant_dcache_q, last_grant_dcache_d;
   logic                  op_write_q, op_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

   logic                  w_ireq;
   logic                  w_dreq;
   logic                  w_pick_dcache;
   logic                  w_serve;

   assign w_ireq  = icache_read;
   assign w_dreq  = dcache_read | dcache_write;
   // D wins when alone, or on a tie when I was the previous owner.
   assign w_pick_dcache = w_dreq & (~w_ireq | ~last_grant_dcache_q);
   assign w_serve = (state_q == ST_SERVE);

   // Next-state and grant-latch logic; inputs are only looked at in IDLE.
   always_comb begin
      state_d             = state_q;
      grant_dcache_d      = grant_dcache_q;
      last_grant_dcache_d = last_grant_dcache_q;
      op_write_d          = op_write_q;
      addr_d              = addr_q;
      wdata_d             = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (w_ireq || w_dreq) begin
               grant_dcache_d      = w_pick_dcache;
               last_grant_dcache_d = w_pick_dcache;
               // Write wins over read if the D-cache asserts both.
               op_write_d          = w_pick_dcache & dcache_write;
               addr_d              = w_pick_dcache ? dcache_address : icache_address;
               if (w_pick_dcache && dcache_write) begin
                  wdata_d = dcache_wdata;
               end
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (pmem_resp) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Guard cycle: a requester still holding its request is not regranted.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched-transaction registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q             <= ST_IDLE;
         grant_dcache_q      <= 1'b0;
         last_grant_dcache_q <= 1'b0;
         op_write_q          <= 1'b0;
         addr_q              <= '0;
         wdata_q             <= '0;
      end else begin
         state_q             <= state_d;
         grant_dcache_q      <= grant_dcache_d;
         last_grant_dcache_q <= last_grant_dcache_d;
         op_write_q          <= op_write_d;
         addr_q              <= addr_d;
         wdata_q             <= wdata_d;
      end
   end

   // Strobes come straight from registered state so reset drops them at once.
   assign pmem_read    = w_serve & ~op_write_q;
   assign pmem_write   = w_serve & op_write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   assign icache_resp  = w_serve & ~grant_dcache_q & pmem_resp;
   assign dcache_resp  = w_serve & grant_dcache_q & pmem_resp;
   assign icache_rdata = pmem_rdata;
   assign dcache_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates cacheline misses from the I-cache and the D-cache onto the single physical-memory port (cacheline adapter side). The I-cache and D-cache miss responses that stall_control_unit sees as instr_mem_resp and data_mem_resp are produced behind this block. A registered, three-state FSM serves one miss at a time. Ties are broken round-robin. Request address and data are latched at grant, so pmem outputs are stable for the whole transaction.

## Interface
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, byte address width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- icache_read  in  1  I-cache line-fill request, held until icache_resp
- icache_address  in  ADDR_WIDTH  line-aligned fill address
- icache_rdata  out  LINE_WIDTH  fill data
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_read  in  1  D-cache line-fill request, held until dcache_resp
- dcache_write  in  1  D-cache writeback request, held until dcache_resp
- dcache_address  in  ADDR_WIDTH  line-aligned address
- dcache_wdata  in  LINE_WIDTH  writeback data
- dcache_rdata  out  LINE_WIDTH  fill data
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_WIDTH  latched address
- pmem_wdata  out  LINE_WIDTH  latched write data
- pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

## Operation
- States:
  - IDLE: no transaction.
  - SERVE: a transaction is outstanding.
  - DONE: one-cycle guard so a requester still asserting its request after resp is not regranted.
- Registers:
  - state
  - grant_d (1 = D-cache owns SERVE)
  - last_grant_d
  - op_write
  - addr_q
  - wdata_q
- IDLE, no request: stay in IDLE.
- IDLE, exactly one cache requesting: grant it.
- IDLE, both requesting: grant the side where last_grant_d differs, i.e. grant D if last_grant_d==0, else grant I.
- On grant:
  - Latch address into addr_q. For a D write, also latch dcache_wdata into wdata_q.
  - Set op_write = dcache_write && grant_d.
  - Set last_grant_d = grant_d.
  - Go to SERVE.
- D-cache with both dcache_read and dcache_write asserted is illegal. Write takes precedence.
- SERVE:
  - pmem_read = !op_write.
  - pmem_write = op_write.
  - pmem_address = addr_q.
  - pmem_wdata = wdata_q.
  - On pmem_resp, go to DONE.
- DONE: no strobes, no resp. Go to IDLE unconditionally.
- icache_resp = (state==SERVE) && !grant_d && pmem_resp. This is combinational, same cycle as pmem_resp.
- dcache_resp = (state==SERVE) && grant_d && pmem_resp.
- icache_rdata = dcache_rdata = pmem_rdata, combinational. Caches consume these only with their resp.
- Requester inputs are ignored outside IDLE. A request that rises during SERVE or DONE waits.
- Reset values:
  - state=IDLE
  - grant_d=0
  - last_grant_d=0, so D wins the first tie
  - op_write=0
  - addr_q=0
  - wdata_q=0
  - All outputs 0, except rdata, which passes through.

## Timing
- Grant latency: a request sampled in IDLE at edge E puts the strobe on pmem at cycle E+1 (registered, no combinational request→pmem path).
- Response latency: resp to the cache is asserted in the same cycle as pmem_resp.
- Turnaround: SERVE→DONE→IDLE. Minimum 2 cycles from pmem_resp to the next pmem strobe. A back-to-back pending request is granted at the IDLE edge.
- Strobes stay constant for the full SERVE state. pmem_address and pmem_wdata do not change while the strobe is high, even if the cache changes its inputs.
- pmem_resp outside SERVE is ignored: no resp pulse, no state change.
- Reset mid-transaction: asynchronous return to IDLE. pmem strobes drop immediately, without waiting for a clock. The outstanding transaction is abandoned. The memory model and the caches are reset by the same rst.
- Starvation bound: with both caches requesting continuously, grants alternate D, I, D, I…

## Test plan
- Single I miss: icache_read=1, address 0x0000_0060. Expect:
  - pmem_read=1, address 0x60, one cycle later.
  - Memory returns pmem_resp after 5 cycles with data 0xAB..AB.
  - icache_resp=1 for exactly one cycle with icache_rdata=0xAB..AB.
  - dcache_resp stays 0.
- D writeback: dcache_write=1, address 0x8000_0100, wdata pattern 0x1234... Expect:
  - pmem_write=1 with address 0x80000100 and the latched wdata.
  - pmem_wdata held even if dcache_wdata is changed mid-SERVE.
  - dcache_resp pulses once.
- Simultaneous requests after reset, I at 0x40 and D read at 0x200. Expect:
  - D served first (address 0x200), then I (0x40).
  - Exactly 2 idle cycles between pmem_resp and the second pmem_read.
- Sustained contention: both caches re-request immediately after each resp for 6 transactions. Expect grant order D, I, D, I, D, I.
- Late request: I requests while D is in SERVE. Expect the I request to be granted in the first IDLE after DONE, with no pmem glitch.
- Reset mid-SERVE: assert rst between clock edges during pmem_read. Expect:
  - pmem_read falls before the next edge.
  - All outputs 0.
  - A new request after reset release is served normally.
  - A spurious pmem_resp arriving while IDLE produces no resp.
